// File: rtl/aixh_mxc_upper_ptile_ncell_pkg.sv
// Shared types for the upper processing-tile cell: command word layout,
// drain sequencer states and the command gating helper.
package aixh_mxc_upper_ptile_ncell_pkg;

    typedef struct packed {
        logic       mac_enable;
        logic       mac_afresh;
        logic       drain_pre;
        logic       drain_req;
        logic [6:0] active_cells;
    } upcell2_command_t;

    localparam int CMD_W      = $bits(upcell2_command_t);
    localparam int DRAIN_WAIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EMIT = 2'd2
    } drain_state_t;

    // A cell beyond the active span sees its enables stripped; the count always decrements.
    function automatic upcell2_command_t gate_cmd(input upcell2_command_t cmd);
        upcell2_command_t gated;
        gated              = cmd;
        gated.active_cells = cmd.active_cells - 7'd1;
        if (cmd.active_cells == 7'd0) begin
            gated.mac_enable = 1'b0;
            gated.drain_pre  = 1'b0;
            gated.drain_req  = 1'b0;
        end else begin
            gated.mac_enable = cmd.mac_enable;
        end
        return gated;
    endfunction

endpackage

// File: rtl/aixh_mxc_upper_ptile_ncell_lane.sv
// One int8 MAC lane: product register, accumulator, bias/scale capture and
// the {scale, bias + acc} drain word.
module aixh_mxc_uptile_lane #(
    parameter int DIN_BITS   = 32,
    parameter int ACCUM_BITS = 32,
    parameter int SCALE_BITS = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             mac_enable,
    input  logic                             mac_afresh,
    input  logic                             drain_pre,
    input  logic                             drain_req,
    input  logic [DIN_BITS-1:0]              slice,
    output logic [ACCUM_BITS+SCALE_BITS-1:0] drain_word
);

    logic signed [15:0]    a_s;
    logic signed [15:0]    w_s;
    logic signed [15:0]    prod_s;
    logic signed [15:0]    prod_r;
    logic                  en_r;
    logic                  fresh_r;
    logic [ACCUM_BITS-1:0] prod_ext_s;
    logic [ACCUM_BITS-1:0] acc_r;
    logic [ACCUM_BITS-1:0] bias_r;
    logic [SCALE_BITS-1:0] scale_r;

    assign a_s        = {{8{slice[7]}}, slice[7:0]};
    assign w_s        = {{8{slice[15]}}, slice[15:8]};
    assign prod_s     = a_s * w_s;
    assign prod_ext_s = ACCUM_BITS'(prod_r);

    // Product stage; afresh travels with enable so the accumulate stage sees a matched pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r  <= 16'sd0;
            en_r    <= 1'b0;
            fresh_r <= 1'b0;
        end else begin
            en_r    <= mac_enable;
            fresh_r <= mac_afresh;
            if (mac_enable) begin
                prod_r <= prod_s;
            end else begin
                prod_r <= prod_r;
            end
        end
    end

    // Accumulate stage, wrapping modulo 2^ACCUM_BITS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= '0;
        end else if (en_r) begin
            acc_r <= fresh_r ? prod_ext_s : acc_r + prod_ext_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    // Bias takes priority over scale when both flags arrive together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_r  <= '0;
            scale_r <= '0;
        end else if (drain_pre) begin
            bias_r  <= slice[ACCUM_BITS-1:0];
        end else if (drain_req) begin
            scale_r <= slice[SCALE_BITS-1:0];
        end else begin
            bias_r  <= bias_r;
        end
    end

    assign drain_word = {scale_r, bias_r + acc_r};

endmodule

// File: rtl/aixh_mxc_upper_ptile_ncell.sv
// Upper processing-tile cell: NUM_LANES MAC lanes, command forwarding, drain
// serialiser and an upstream skid FIFO merged onto the horizontal drain chain.
module aixh_mxc_upper_ptile_ncell
    import aixh_mxc_upper_ptile_ncell_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int DIN_BITS   = 32,
    parameter int ACCUM_BITS = 32,
    parameter int SCALE_BITS = 16,
    parameter int SKEW_DEPTH = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             aixh_core_clk2x,
    input  logic                             aixh_core_rstn,
    input  logic [CMD_W-1:0]                 i_upc_cmd,
    output logic [CMD_W-1:0]                 o_upc_cmd,
    input  logic [NUM_LANES*DIN_BITS-1:0]    i_uqc_dat,
    input  logic                             i_upc_vld,
    input  logic [ACCUM_BITS+SCALE_BITS-1:0] i_upc_dat,
    output logic                             o_upc_vld,
    output logic [ACCUM_BITS+SCALE_BITS-1:0] o_upc_dat,
    output logic [1:0]                       o_err
);

    localparam int DW     = ACCUM_BITS + SCALE_BITS;
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    // The trigger cycle counts toward the wait, so WAIT itself lasts DRAIN_WAIT-1 cycles.
    localparam logic [1:0]        WAIT_LOAD = 2'(DRAIN_WAIT - 2);

    upcell2_command_t              cmd_s;
    upcell2_command_t              cmd_r;
    logic [NUM_LANES*DIN_BITS-1:0] dat_s;
    logic [DW-1:0]                 lane_word_s [NUM_LANES];

    drain_state_t      state_r;
    drain_state_t      state_s;
    logic [1:0]        wait_cnt_r;
    logic [1:0]        wait_cnt_s;
    logic [LANE_W-1:0] lane_cnt_r;
    logic [LANE_W-1:0] lane_cnt_s;

    logic [DW-1:0]     mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              emit_s;
    logic              pop_s;
    logic              push_req_s;
    logic              push_s;
    logic              ovf_s;
    logic              collide_s;

    logic              out_vld_r;
    logic [DW-1:0]     out_dat_r;
    logic [1:0]        err_r;

    assign cmd_s = gate_cmd(upcell2_command_t'(i_upc_cmd));

    // Gated command register, forwarded to the next cell and used locally.
    always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn) begin
        if (!aixh_core_rstn) begin
            cmd_r <= '0;
        end else begin
            cmd_r <= cmd_s;
        end
    end

    assign o_upc_cmd = cmd_r;

    if (SKEW_DEPTH == 0) begin : g_noskew
        assign dat_s = i_uqc_dat;
    end else begin : g_skew
        logic [NUM_LANES*DIN_BITS-1:0] pipe_r [SKEW_DEPTH];

        // Operand skew line.
        always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn) begin
            if (!aixh_core_rstn) begin
                for (int i = 0; i < SKEW_DEPTH; i++) pipe_r[i] <= '0;
            end else begin
                pipe_r[0] <= i_uqc_dat;
                for (int i = 1; i < SKEW_DEPTH; i++) pipe_r[i] <= pipe_r[i-1];
            end
        end

        assign dat_s = pipe_r[SKEW_DEPTH-1];
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        aixh_mxc_uptile_lane #(
            .DIN_BITS   (DIN_BITS),
            .ACCUM_BITS (ACCUM_BITS),
            .SCALE_BITS (SCALE_BITS)
        ) u_lane (
            .clk        (aixh_core_clk2x),
            .rst_n      (aixh_core_rstn),
            .mac_enable (cmd_r.mac_enable),
            .mac_afresh (cmd_r.mac_afresh),
            .drain_pre  (cmd_r.drain_pre),
            .drain_req  (cmd_r.drain_req),
            .slice      (dat_s[l*DIN_BITS +: DIN_BITS]),
            .drain_word (lane_word_s[l])
        );
    end

    // Drain sequencer next-state logic.
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        lane_cnt_s = lane_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_r.drain_req) begin
                    state_s    = ST_WAIT;
                    wait_cnt_s = WAIT_LOAD;
                    lane_cnt_s = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == 2'd0) begin
                    state_s    = ST_EMIT;
                    lane_cnt_s = '0;
                end else begin
                    wait_cnt_s = wait_cnt_r - 2'd1;
                end
            end
            ST_EMIT: begin
                if (lane_cnt_r == LAST_LANE) begin
                    state_s = ST_IDLE;
                end else begin
                    lane_cnt_s = lane_cnt_r + LANE_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Drain sequencer state.
    always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn) begin
        if (!aixh_core_rstn) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 2'd0;
            lane_cnt_r <= '0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            lane_cnt_r <= lane_cnt_s;
        end
    end

    assign emit_s     = (state_r == ST_EMIT);
    assign collide_s  = cmd_r.drain_req && (state_r != ST_IDLE);
    assign pop_s      = !emit_s && (count_r != '0);
    // Once anything is queued, later upstream words must queue behind it to keep order.
    assign push_req_s = i_upc_vld && (emit_s || (count_r != '0));
    assign push_s     = push_req_s && ((count_r != FULL_CNT) || pop_s);
    assign ovf_s      = push_req_s && (count_r == FULL_CNT) && !pop_s;

    // Upstream skid FIFO storage and pointers.
    always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn) begin
        if (!aixh_core_rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= i_upc_dat;
                wr_ptr_r        <= (wr_ptr_r == LAST_PTR) ? '0 : wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == LAST_PTR) ? '0 : rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // Output arbitration: local lane, then queued upstream, then upstream pass-through.
    always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn) begin
        if (!aixh_core_rstn) begin
            out_vld_r <= 1'b0;
            out_dat_r <= '0;
        end else if (emit_s) begin
            out_vld_r <= 1'b1;
            out_dat_r <= lane_word_s[lane_cnt_r];
        end else if (pop_s) begin
            out_vld_r <= 1'b1;
            out_dat_r <= mem_r[rd_ptr_r];
        end else if (i_upc_vld) begin
            out_vld_r <= 1'b1;
            out_dat_r <= i_upc_dat;
        end else begin
            out_vld_r <= 1'b0;
            out_dat_r <= out_dat_r;
        end
    end

    // Sticky error flags.
    always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn) begin
        if (!aixh_core_rstn) begin
            err_r <= 2'b00;
        end else begin
            err_r <= err_r | {ovf_s, collide_s};
        end
    end

    assign o_upc_vld = out_vld_r;
    assign o_upc_dat = out_dat_r;
    assign o_err     = err_r;

endmodule

// File: tb/tb_aixh_mxc_upper_ptile_ncell.sv
// Directed bench: table of gating vectors plus hand-built drain, FIFO,
// collision, wrap and mid-drain reset sequences with hand-computed results.
module tb_aixh_mxc_upper_ptile_ncell;
    import aixh_mxc_upper_ptile_ncell_pkg::*;

    localparam int NL = 4;
    localparam int DB = 32;
    localparam int DW = 48;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [CMD_W-1:0]   cmd_in = '0;
    logic [CMD_W-1:0]   cmd_out;
    logic [NL*DB-1:0]   uqc = '0;
    logic [NL*DB-1:0]   pend_dat = '0;
    logic               upc_vld_in = 1'b0;
    logic [DW-1:0]      upc_dat_in = '0;
    logic               vld_out;
    logic [DW-1:0]      dat_out;
    logic [1:0]         err;

    aixh_mxc_upper_ptile_ncell dut (
        .aixh_core_clk2x (clk),
        .aixh_core_rstn  (rst_n),
        .i_upc_cmd       (cmd_in),
        .o_upc_cmd       (cmd_out),
        .i_uqc_dat       (uqc),
        .i_upc_vld       (upc_vld_in),
        .i_upc_dat       (upc_dat_in),
        .o_upc_vld       (vld_out),
        .o_upc_dat       (dat_out),
        .o_err           (err)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct { int cyc; logic [DW-1:0] dat; } word_t;
    word_t log_q[$];
    word_t exp_q[$];

    always @(negedge clk) if (rst_n && vld_out) log_q.push_back('{cycle, dat_out});

    typedef struct { logic [CMD_W-1:0] cmd; logic [CMD_W-1:0] exp; } vec_t;
    vec_t vecs[6];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, expv);
    endtask

    function automatic logic [CMD_W-1:0] mkcmd(input logic en, input logic fr, input logic pre,
                                              input logic req, input logic [6:0] ac);
        upcell2_command_t c;
        c.mac_enable = en; c.mac_afresh = fr; c.drain_pre = pre; c.drain_req = req;
        c.active_cells = ac;
        return c;
    endfunction

    function automatic logic [NL*DB-1:0] lanes(input logic [DB-1:0] s0, input logic [DB-1:0] s1,
                                               input logic [DB-1:0] s2, input logic [DB-1:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Operand data follows its command by one cycle, so it is staged through pend_dat.
    task automatic op(input logic [CMD_W-1:0] c, input logic [NL*DB-1:0] d,
                      input logic uv, input logic [DW-1:0] ud);
        cmd_in     = c;
        uqc        = pend_dat;
        pend_dat   = d;
        upc_vld_in = uv;
        upc_dat_in = ud;
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cmd_in = '0; uqc = '0; pend_dat = '0; upc_vld_in = 1'b0; upc_dat_in = '0;
        step(); step();
        rst_n = 1'b1;
        step();
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic compare_log(input string name);
        check({name, " count"}, 64'(log_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check($sformatf("%s word%0d data", name, i), 64'(log_q[i].dat), 64'(exp_q[i].dat));
            check($sformatf("%s word%0d cycle", name, i), 64'(log_q[i].cyc), 64'(exp_q[i].cyc));
        end
    endtask

    localparam logic [CMD_W-1:0] IDLE_CMD = 11'd0;

    initial begin
        int t;
        logic [CMD_W-1:0] c;
        logic [NL*DB-1:0] d;
        logic [DW-1:0]    ubase;

        vecs[0] = '{mkcmd(1'b1, 1'b0, 1'b0, 1'b1, 7'd0),   mkcmd(1'b0, 1'b0, 1'b0, 1'b0, 7'd127)};
        vecs[1] = '{mkcmd(1'b1, 1'b1, 1'b1, 1'b1, 7'd0),   mkcmd(1'b0, 1'b1, 1'b0, 1'b0, 7'd127)};
        vecs[2] = '{mkcmd(1'b0, 1'b1, 1'b0, 1'b0, 7'd1),   mkcmd(1'b0, 1'b1, 1'b0, 1'b0, 7'd0)};
        vecs[3] = '{mkcmd(1'b1, 1'b0, 1'b0, 1'b0, 7'd5),   mkcmd(1'b1, 1'b0, 1'b0, 1'b0, 7'd4)};
        vecs[4] = '{mkcmd(1'b0, 1'b0, 1'b1, 1'b0, 7'd127), mkcmd(1'b0, 1'b0, 1'b1, 1'b0, 7'd126)};
        vecs[5] = '{mkcmd(1'b0, 1'b0, 1'b0, 1'b0, 7'd64),  mkcmd(1'b0, 1'b0, 1'b0, 1'b0, 7'd63)};

        #2;
        check("reset cmd", 64'(cmd_out), 64'd0);
        check("reset vld", 64'(vld_out), 64'd0);
        check("reset dat", 64'(dat_out), 64'd0);
        check("reset err", 64'(err), 64'd0);
        do_reset();

        for (int i = 0; i < 6; i++) begin
            op(vecs[i].cmd, '0, 1'b0, '0);
            check($sformatf("gate vec%0d", i), 64'(cmd_out), 64'(vecs[i].exp));
        end

        // Gated MAC and gated drain must leave lanes untouched and emit nothing.
        do_reset();
        for (int k = 0; k < 14; k++) begin
            c = IDLE_CMD; d = '0;
            if (k == 0) begin c = mkcmd(1'b1, 1'b1, 1'b0, 1'b0, 7'd0); d = {NL{32'h0000_0303}}; end
            if (k == 1) begin c = mkcmd(1'b0, 1'b0, 1'b0, 1'b1, 7'd0); d = {NL{32'h0000_0007}}; end
            if (k == 2) begin c = mkcmd(1'b0, 1'b0, 1'b1, 1'b0, 7'd1); d = '0; end
            if (k == 3) begin c = mkcmd(1'b0, 1'b0, 1'b0, 1'b1, 7'd1); d = {NL{32'h0000_0022}}; t = cycle; end
            op(c, d, 1'b0, '0);
        end
        for (int l = 0; l < NL; l++) exp_q.push_back('{t + 4 + l, {16'h0022, 32'd0}});
        compare_log("gated");
        check("gated err", 64'(err), 64'd0);

        // Basic drain: a=l+1, w=-2 over three cycles, bias 100, scale 0x10.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            c = IDLE_CMD; d = '0;
            if (k < 3) begin
                c = mkcmd(1'b1, (k == 0), 1'b0, 1'b0, 7'd1);
                d = lanes(32'h0000_FE01, 32'h0000_FE02, 32'h0000_FE03, 32'h0000_FE04);
            end
            if (k == 3) begin c = mkcmd(1'b0, 1'b0, 1'b1, 1'b0, 7'd1); d = {NL{32'd100}}; end
            if (k == 4) begin c = mkcmd(1'b0, 1'b0, 1'b0, 1'b1, 7'd1); d = {NL{32'h0000_0010}}; t = cycle; end
            op(c, d, 1'b0, '0);
        end
        exp_q.push_back('{t + 4, {16'h0010, 32'd94}});
        exp_q.push_back('{t + 5, {16'h0010, 32'd88}});
        exp_q.push_back('{t + 6, {16'h0010, 32'd82}});
        exp_q.push_back('{t + 7, {16'h0010, 32'd76}});
        compare_log("drain");

        // Upstream burst across two back-to-back drains: 2 words dropped, order kept.
        do_reset();
        ubase = 48'hC0DE_0000_0000;
        for (int k = 0; k < 25; k++) begin
            c = IDLE_CMD; d = '0;
            if (k == 0) begin c = mkcmd(1'b0, 1'b0, 1'b1, 1'b0, 7'd2); d = lanes(32'd1, 32'd2, 32'd3, 32'd4); end
            if (k == 1) begin c = mkcmd(1'b0, 1'b0, 1'b0, 1'b1, 7'd2); d = {NL{32'h0000_000A}}; t = cycle; end
            if (k == 7) begin c = mkcmd(1'b0, 1'b0, 1'b0, 1'b1, 7'd2); d = {NL{32'h0000_000B}}; end
            if (k >= 4 && k <= 11) op(c, d, 1'b1, ubase + 48'(k - 4));
            else if (k == 20)      op(c, d, 1'b1, ubase + 48'd8);
            else                   op(c, d, 1'b0, '0);
        end
        for (int l = 0; l < NL; l++) exp_q.push_back('{t + 4 + l, {16'h000A, 32'(l + 1)}});
        exp_q.push_back('{t + 8, ubase});
        exp_q.push_back('{t + 9, ubase + 48'd1});
        for (int l = 0; l < NL; l++) exp_q.push_back('{t + 10 + l, {16'h000B, 32'(l + 1)}});
        for (int i = 0; i < 4; i++) exp_q.push_back('{t + 14 + i, ubase + 48'(2 + i)});
        exp_q.push_back('{t + 20, ubase + 48'd8});
        compare_log("fifo");
        check("fifo err", 64'(err), 64'd2);
        check("hold vld", 64'(vld_out), 64'd0);
        check("hold dat", 64'(dat_out), 64'(ubase + 48'd8));

        // Second drain_req while busy: flagged, still exactly four local words.
        do_reset();
        for (int k = 0; k < 15; k++) begin
            c = IDLE_CMD; d = '0;
            if (k == 0) begin c = mkcmd(1'b0, 1'b0, 1'b1, 1'b0, 7'd3); d = lanes(32'h1000, 32'h1001, 32'h1002, 32'h1003); end
            if (k == 1) begin c = mkcmd(1'b0, 1'b0, 1'b0, 1'b1, 7'd3); d = {NL{32'd5}}; t = cycle; end
            if (k == 3) begin c = mkcmd(1'b0, 1'b0, 1'b0, 1'b1, 7'd3); d = {NL{32'd5}}; end
            op(c, d, 1'b0, '0);
        end
        for (int l = 0; l < NL; l++) exp_q.push_back('{t + 4 + l, {16'h0005, 32'h1000 + 32'(l)}});
        compare_log("collide");
        check("collide err", 64'(err), 64'd1);

        // Signed products and modular wrap in the drain adder.
        do_reset();
        for (int k = 0; k < 14; k++) begin
            c = IDLE_CMD; d = '0;
            if (k == 0) begin c = mkcmd(1'b1, 1'b1, 1'b0, 1'b0, 7'd1); d = lanes(32'h0101, 32'h01FF, 32'h8080, 32'h807F); end
            if (k == 1) begin c = mkcmd(1'b0, 1'b0, 1'b1, 1'b0, 7'd1); d = lanes(32'h7FFF_FFFF, 32'h0, 32'hFFFF_C000, 32'h8000_0000); end
            if (k == 2) begin c = mkcmd(1'b0, 1'b0, 1'b0, 1'b1, 7'd1); d = {NL{32'h0000_FFFF}}; t = cycle; end
            op(c, d, 1'b0, '0);
        end
        exp_q.push_back('{t + 4, {16'hFFFF, 32'h8000_0000}});
        exp_q.push_back('{t + 5, {16'hFFFF, 32'hFFFF_FFFF}});
        exp_q.push_back('{t + 6, {16'hFFFF, 32'h0000_0000}});
        exp_q.push_back('{t + 7, {16'hFFFF, 32'h7FFF_C080}});
        compare_log("wrap");

        // Reset during EMIT of lane 1 aborts the drain and clears the sticky error.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            c = IDLE_CMD; d = '0;
            if (k == 0) begin c = mkcmd(1'b0, 1'b0, 1'b1, 1'b0, 7'd1); d = {NL{32'h55}}; end
            if (k == 1) begin c = mkcmd(1'b0, 1'b0, 1'b0, 1'b1, 7'd1); d = {NL{32'h3}}; end
            if (k == 3) begin c = mkcmd(1'b0, 1'b0, 1'b0, 1'b1, 7'd1); d = {NL{32'h3}}; end
            op(c, d, 1'b0, '0);
        end
        check("pre-rst vld", 64'(vld_out), 64'd1);
        check("pre-rst err", 64'(err), 64'd1);
        rst_n = 1'b0; cmd_in = '0; uqc = '0; pend_dat = '0;
        #1;
        check("rst cmd", 64'(cmd_out), 64'd0);
        check("rst vld", 64'(vld_out), 64'd0);
        check("rst dat", 64'(dat_out), 64'd0);
        check("rst err", 64'(err), 64'd0);
        step(); step();
        rst_n = 1'b1;
        log_q.delete();
        for (int k = 0; k < 10; k++) op(IDLE_CMD, '0, 1'b0, '0);
        check("post-rst words", 64'(log_q.size()), 64'd0);
        check("post-rst err", 64'(err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aixh_mxc_upper_ptile_ncell.md
Name: aixh_mxc_upper_ptile_ncell

Overview:
Parametrised next-generation upper processing-tile cell. It holds NUM_LANES independent int8 MAC lanes (the previous cell had exactly two) and forwards the horizontal command chain. It serialises per-lane drain results (bias + accumulator, plus scale) onto the horizontal drain chain. Upstream drain words that collide with local emission are buffered in a skid FIFO instead of being dropped.

Parameters:
NUM_LANES, 4, number of MAC lanes (1..16)
DIN_BITS, 32, per-lane input slice width on i_uqc_dat (>= max(16, ACCUM_BITS, SCALE_BITS))
ACCUM_BITS, 32, accumulator and bias width
SCALE_BITS, 16, scale width
SKEW_DEPTH, 0, register stages applied to i_uqc_dat (0..8)
FIFO_DEPTH, 4, depth of the upstream drain skid FIFO (>= 1)

Ports:
aixh_core_clk2x  in  1  sole clock, rising edge
aixh_core_rstn  in  1  asynchronous, active-low reset
i_upc_cmd  in  CMD_W  command: mac_enable, mac_afresh, drain_pre, drain_req, active_cells[6:0]
o_upc_cmd  out  CMD_W  registered, gated command to next cell
i_uqc_dat  in  NUM_LANES*DIN_BITS  per-lane operand/bias/scale slices
i_upc_vld  in  1  upstream drain word valid
i_upc_dat  in  ACCUM_BITS+SCALE_BITS  upstream drain word
o_upc_vld  out  1  drain word valid
o_upc_dat  out  ACCUM_BITS+SCALE_BITS  {scale, value}
o_err  out  2  sticky: [0] drain collision, [1] FIFO overflow

Behaviour:
- Reset: all outputs 0; accumulators, biases, scales, FIFO, sequencer and r_cmd cleared. Reset asserted mid-drain aborts the drain with no partial output after release.
- Gating (comb): active_cells_out = active_cells-1 (7-bit wrap). If active_cells==0, clear mac_enable, drain_pre and drain_req. Other fields pass unchanged.
- Command: i_upc_cmd at cycle t drives r_cmd at t+1; o_upc_cmd = r_cmd.
- Operands: d = i_uqc_dat delayed SKEW_DEPTH registers, used together with r_cmd. Lane l slice is d[l*DIN_BITS +: DIN_BITS]: a = s[7:0], w = s[15:8], both signed.
- MAC:
  - t+1, r_cmd.mac_enable: product p_l = a*w (signed 16b) registered at t+2.
  - t+3: acc_l = afresh ? sext(p_l) : acc_l + sext(p_l), modulo 2^ACCUM_BITS. The afresh flag is carried in the same pipe as enable.
  - Disabled cycle leaves acc_l unchanged.
- Bias and scale capture:
  - r_cmd.drain_pre: bias_l <= s[ACCUM_BITS-1:0].
  - r_cmd.drain_req (checked only when drain_pre is 0): scale_l <= s[SCALE_BITS-1:0].
- Drain sequencer: states IDLE -> WAIT (2 cycles) -> EMIT (NUM_LANES cycles, lane counter 0..NUM_LANES-1) -> IDLE.
  - Trigger: r_cmd.drain_req at t+1.
  - Lane l is emitted at t+4+l with o_upc_dat = {scale_l, bias_l + acc_l (wrap)}.
  - The last MAC's r_cmd must be at cycle <= t.
  - drain_req while not IDLE: ignored, o_err[0] set.
- Output arbitration, registered with 1-cycle latency:
  1. local EMIT word;
  2. else FIFO head (pop);
  3. else i_upc word direct.
- FIFO push: i_upc_vld in the same cycle as local EMIT or with FIFO non-empty. Order is preserved.
- Pop and push in the same cycle are both allowed.
- Push when full with no pop: word dropped, o_err[1] set.
- o_upc_vld = 0 when no source is available; o_upc_dat holds its last value.
- o_err bits clear only on reset.

Decomposition:
- AIXH_MXC_pkg gains:
  - UPCELL2_Command packed struct (fields above; CMD_W = $bits);
  - DRAIN_WAIT=2 constant;
  - drain FSM state enum.
- Sub-module aixh_mxc_uptile_lane: one lane (product register, accumulator, bias/scale registers, drain value adder), generated NUM_LANES times.
- The FIFO stays inline.

Test Plan:
1. active_cells=0 with mac_enable=1, drain_req=1 -> o_upc_cmd.active_cells=127, mac_enable=0, drain_req=0; accumulators unchanged; no emission.
2. NUM_LANES=4, lane l gets a=l+1, w=-2 for 3 cycles (first afresh), then drain_pre bias=100, drain_req scale=0x0010 -> emitted words, one per cycle at t+4..t+7:
   - lane 0: {0x0010, 94}
   - lane 1: {0x0010, 88}
   - lane 2: {0x0010, 82}
   - lane 3: {0x0010, 76}
3. i_upc_vld bursts 6 words during local EMIT with FIFO_DEPTH=4 -> 4 buffered, emitted in order after lane 3, 2 dropped; o_err=2'b10.
4. Second drain_req 2 cycles after the first -> o_err[0]=1; exactly 4 local words emitted.
5. Accumulator wrap: acc=0x7FFF_FFFF plus p=1 -> 0x8000_0000, drained with bias 0.
6. aixh_core_rstn pulsed low during EMIT of lane 1 -> all outputs 0 immediately; no further local words; o_err=0.
